cache_controller: RTL and testbench

- 2-way set-associative read cache between the MEM pipeline stage and the SRAM controller.
- Serves 32-bit loads from a 64-bit-line cache; on a miss, fetches a whole 64-bit line (four 16-bit SRAM words) downstream.
- Stores are write-through, no-write-allocate.
- Drives `freeze` to stall the pipeline until the access completes.

---
 rtl/cache_controller_pkg.sv | 29 ++
 rtl/cache_way_array.sv | 47 ++++
 rtl/cache_controller.sv | 147 ++++++++++++++
 tb/tb_cache_controller.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/cache_controller_pkg.sv
// Shared types and address-field layout for the 2-way read cache.
package cache_controller_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WTHRU
  } state_e;

  localparam logic [31:0] BASE_ADDR = 32'd1024;
  localparam int SETS    = 64;
  localparam int IDX_W   = 6;
  localparam int TAG_W   = 10;
  localparam int LINE_W  = 64;
  localparam int WORD_W  = 32;
  localparam int OFF_BIT = 2;
  localparam int IDX_LSB = 3;
  localparam int IDX_MSB = 8;
  localparam int TAG_LSB = 9;
  localparam int TAG_MSB = 18;

  function automatic logic [WORD_W-1:0] sel_word(
    input logic [LINE_W-1:0] line,
    input logic              hi
  );
    return hi ? line[63:32] : line[31:0];
  endfunction

endpackage

// File: rtl/cache_way_array.sv
// One way of the cache: valid/tag/data per set, indexed combinational read,
// full-line fill and half-line write ports.
module cache_way_array
  import cache_controller_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic              fill_i,
  input  logic [TAG_W-1:0]  tag_i,
  input  logic [LINE_W-1:0] line_i,
  input  logic              wr_i,
  input  logic              wr_hi_i,
  input  logic [WORD_W-1:0] word_i,
  output logic              valid_o,
  output logic [TAG_W-1:0]  tag_o,
  output logic [LINE_W-1:0] line_o
);

  logic [SETS-1:0]   valid_q;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [LINE_W-1:0] data_q [SETS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (fill_i) begin
      valid_q[idx_i] <= 1'b1;
    end
  end

  // Tag and data need no reset: valid gates every use.
  always_ff @(posedge clk) begin
    if (fill_i) begin
      tag_q[idx_i]  <= tag_i;
      data_q[idx_i] <= line_i;
    end else if (wr_i) begin
      if (wr_hi_i) data_q[idx_i][63:32] <= word_i;
      else         data_q[idx_i][31:0]  <= word_i;
    end
  end

  assign valid_o = valid_q[idx_i];
  assign tag_o   = tag_q[idx_i];
  assign line_o  = data_q[idx_i];

endmodule

// File: rtl/cache_controller.sv
// 2-way set-associative read cache, write-through / no-write-allocate,
// between the MEM stage and the SRAM controller.
module cache_controller
  import cache_controller_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        freeze,
  output logic [17:0] sram_address,
  output logic [31:0] sram_wdata,
  output logic        sram_read,
  output logic        sram_write,
  input  logic [63:0] sram_rdata,
  input  logic        sram_ready
);

  state_e          state_q;
  logic [SETS-1:0] lru_q;

  logic [31:0]      eff;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             hi;
  logic             unused_eff;

  assign eff        = address - BASE_ADDR;
  assign idx        = eff[IDX_MSB:IDX_LSB];
  assign tag        = eff[TAG_MSB:TAG_LSB];
  assign hi         = eff[OFF_BIT];
  assign unused_eff = ^{eff[31:19], eff[1:0]};

  logic              v0, v1;
  logic [TAG_W-1:0]  t0, t1;
  logic [LINE_W-1:0] l0, l1;
  logic              hit0, hit1, hit;
  logic              fill, wr_hit;

  assign hit0 = v0 & (t0 == tag);
  assign hit1 = v1 & (t1 == tag);
  assign hit  = hit0 | hit1;

  cache_way_array u_way0 (
    .clk     (clk),
    .rst     (rst),
    .idx_i   (idx),
    .fill_i  (fill & ~lru_q[idx]),
    .tag_i   (tag),
    .line_i  (sram_rdata),
    .wr_i    (wr_hit & hit0),
    .wr_hi_i (hi),
    .word_i  (wdata),
    .valid_o (v0),
    .tag_o   (t0),
    .line_o  (l0)
  );

  cache_way_array u_way1 (
    .clk     (clk),
    .rst     (rst),
    .idx_i   (idx),
    .fill_i  (fill & lru_q[idx]),
    .tag_i   (tag),
    .line_i  (sram_rdata),
    .wr_i    (wr_hit & hit1),
    .wr_hi_i (hi),
    .word_i  (wdata),
    .valid_o (v1),
    .tag_o   (t1),
    .line_o  (l1)
  );

  // Outputs are decoded from state so a hit can complete in the same cycle.
  always_comb begin
    ready        = 1'b0;
    rdata        = '0;
    sram_read    = 1'b0;
    sram_write   = 1'b0;
    sram_address = '0;
    sram_wdata   = '0;
    fill         = 1'b0;
    wr_hit       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_write) begin
          wr_hit = hit;
        end else if (mem_read && hit) begin
          ready = 1'b1;
          rdata = sel_word(hit1 ? l1 : l0, hi);
        end
      end
      FILL: begin
        sram_read    = 1'b1;
        sram_address = {eff[18:3], 2'b00};
        if (sram_ready) begin
          ready = 1'b1;
          fill  = 1'b1;
          rdata = sel_word(sram_rdata, hi);
        end
      end
      WTHRU: begin
        sram_write   = 1'b1;
        sram_address = {eff[18:2], 1'b0};
        sram_wdata   = wdata;
        ready        = sram_ready;
      end
      default: ;
    endcase
  end

  assign freeze = (mem_read | mem_write) & ~ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      lru_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (mem_write) begin
            state_q <= WTHRU;
            if (hit) lru_q[idx] <= ~hit1;
          end else if (mem_read) begin
            if (hit) lru_q[idx] <= ~hit1;
            else     state_q    <= FILL;
          end
        end
        FILL: begin
          if (sram_ready) begin
            lru_q[idx] <= ~lru_q[idx];
            state_q    <= IDLE;
          end
        end
        WTHRU: begin
          if (sram_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// Scoreboard bench for cache_controller with a fixed-latency SRAM model.
module tb_cache_controller;

  localparam int LAT = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [31:0] address, wdata, rdata;
  logic        ready, freeze;
  logic [17:0] sram_address;
  logic [31:0] sram_wdata;
  logic        sram_read, sram_write;
  logic [63:0] sram_rdata;
  logic        sram_ready;

  int n_chk  = 0;
  int n_pass = 0;

  cache_controller dut (
    .clk          (clk),
    .rst          (rst),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .address      (address),
    .wdata        (wdata),
    .rdata        (rdata),
    .ready        (ready),
    .freeze       (freeze),
    .sram_address (sram_address),
    .sram_wdata   (sram_wdata),
    .sram_read    (sram_read),
    .sram_write   (sram_write),
    .sram_rdata   (sram_rdata),
    .sram_ready   (sram_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else
      n_pass++;
  endtask

  // SRAM model: line-addressed memory with a default pattern
  logic [63:0] mem [int];
  int          obs_kind;
  logic [17:0] obs_sa;
  logic [31:0] obs_wd;

  function automatic logic [63:0] rd_line(input int l);
    if (mem.exists(l)) return mem[l];
    return {32'hB000_0000 | l, 32'hA000_0000 | l};
  endfunction

  initial begin
    int cnt;
    int l;
    logic [63:0] v;
    cnt        = 0;
    sram_ready = 1'b0;
    sram_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        cnt        = 0;
        sram_ready = 1'b0;
      end else if (sram_ready) begin
        sram_ready = 1'b0;
        cnt        = 0;
      end else if (sram_read || sram_write) begin
        chk("excl", {sram_read, sram_write}, 2'b10 >> sram_write);
        if (cnt == 0) begin
          obs_kind = sram_write ? 2 : 1;
          obs_sa   = sram_address;
          obs_wd   = sram_wdata;
        end
        cnt++;
        if (cnt == LAT) begin
          l = int'(sram_address >> 2);
          if (sram_write) begin
            v = rd_line(l);
            if (sram_address[1]) v[63:32] = sram_wdata;
            else                 v[31:0]  = sram_wdata;
            mem[l] = v;
          end else begin
            sram_rdata = rd_line(l);
          end
          sram_ready = 1'b1;
        end
      end
    end
  end

  typedef struct {
    logic [31:0] rd;
    bit          chk_rd;
    int          stall;
    int          kind;
    logic [17:0] sa;
    logic [31:0] wd;
  } exp_t;

  exp_t sb[$];

  task automatic issue(input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] er, input bit chk_rd,
                       input int es, input int ek,
                       input logic [17:0] esa, input logic [31:0] ewd);
    exp_t        e;
    int          cyc;
    bit          done;
    logic [31:0] got;
    sb.push_back('{er, chk_rd, es, ek, esa, ewd});
    @(posedge clk);
    #1;
    obs_kind  = 0;
    mem_read  = rd;
    mem_write = wr;
    address   = a;
    wdata     = wd;
    cyc  = 0;
    done = 0;
    got  = '0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      if (ready) begin
        done = 1;
        got  = rdata;
      end else begin
        chk("freeze", freeze, 1'b1);
        cyc++;
      end
    end
    chk("timeout", done, 1'b1);
    e = sb.pop_front();
    chk("stall", cyc, e.stall);
    if (e.chk_rd) chk("rdata", got, e.rd);
    chk("kind", obs_kind, e.kind);
    if (e.kind != 0) chk("saddr", obs_sa, e.sa);
    if (e.kind == 2) chk("swdata", obs_wd, e.wd);
    @(posedge clk);
    #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic pulse_rst();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    address   = '0;
    wdata     = '0;
    obs_kind  = 0;
    obs_sa    = '0;
    obs_wd    = '0;
    mem[0]    = 64'h1111_2222_3333_4444;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", ready, 1'b0);
    chk("rst_freeze", freeze, 1'b0);
    chk("rst_sread", sram_read, 1'b0);
    chk("rst_swrite", sram_write, 1'b0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_saddr", sram_address, 18'h0);
    rst = 1'b0;

    // write miss to an empty set, then read misses (no allocate)
    issue(0, 1, 2048, 32'hCAFE_F00D, 0, 0, LAT, 2, 18'd512, 32'hCAFE_F00D);
    issue(1, 0, 2048, 0, 32'hCAFE_F00D, 1, LAT, 1, 18'd512, 0);
    pulse_rst();

    // cold read, hit, write hit, both requests
    issue(1, 0, 1024, 0, 32'h3333_4444, 1, LAT, 1, 18'd0, 0);
    issue(1, 0, 1028, 0, 32'h1111_2222, 1, 0, 0, 0, 0);
    issue(0, 1, 1028, 32'hDEAD_BEEF, 0, 0, LAT, 2, 18'd2, 32'hDEAD_BEEF);
    issue(1, 0, 1028, 0, 32'hDEAD_BEEF, 1, 0, 0, 0, 0);
    issue(1, 1, 1028, 32'h1234_5678, 0, 0, LAT, 2, 18'd2, 32'h1234_5678);
    issue(1, 0, 1028, 0, 32'h1234_5678, 1, 0, 0, 0, 0);

    // LRU eviction in set 0
    issue(1, 0, 1536, 0, 32'hA000_0040, 1, LAT, 1, 18'd256, 0);
    issue(1, 0, 2048, 0, 32'hCAFE_F00D, 1, LAT, 1, 18'd512, 0);
    issue(1, 0, 1536, 0, 32'hA000_0040, 1, 0, 0, 0, 0);
    issue(1, 0, 1024, 0, 32'h3333_4444, 1, LAT, 1, 18'd0, 0);

    // reset in the middle of a line fill
    @(posedge clk);
    #1;
    mem_read = 1'b1;
    address  = 3072;
    repeat (2) @(posedge clk);
    #1;
    chk("fill_sread", sram_read, 1'b1);
    rst = 1'b1;
    #1;
    chk("arst_sread", sram_read, 1'b0);
    chk("arst_ready", ready, 1'b0);
    mem_read = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    issue(1, 0, 1024, 0, 32'h3333_4444, 1, LAT, 1, 18'd0, 0);

    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
